sw_accum_adder: RTL
===================

// Module: sw_accum_adder
// PURPOSE
//  Board-level switch adder, next generation: parametrised operand width, button-stepped accumulator,
//  add/subtract mode, sticky overflow flag and registered LED display. Sits directly between board
//  switches/push-buttons and the LED bank. Buttons are synchronised and debounced internally.
// PARAMETERS
//  WIDTH            3        operand width; num1 = sw[WIDTH-1:0], num2 = sw[2*WIDTH-1:WIDTH]
//  ACC_W            7        accumulator width; led width is ACC_W+1; require 2*WIDTH <= ACC_W+1
//  DEBOUNCE_CYCLES  250000   consecutive stable samples needed to accept a button level change (>=2)
// PORTS
//  clk      in   1            board clock; only clock in the block
//  rst      in   1            synchronous, active-high reset
//  sw       in   2*WIDTH+2    [2W-1:0] operands; sw[2W] sub (1 = subtract); sw[2W+1] disp_sel
//  btn_step in   1            raw push-button: apply num1+num2 to accumulator
//  btn_clr  in   1            raw push-button: clear accumulator and overflow flag
//  led      out  ACC_W+1      registered display
// BEHAVIOUR
//  - Reset: acc=0, ovf=0, led=0, both debouncers in S_LOW with counter 0 and sync flops 0.
//  - Operand sum: sum = num1 + num2, WIDTH+1 bits, zero-extended to ACC_W. sw is quasi-static, not synchronised.
//  - Debouncer (per button): 2-FF synchroniser, then FSM S_LOW -> S_RISE (synced=1) -> S_HIGH after
//    DEBOUNCE_CYCLES consecutive 1 samples; S_RISE -> S_LOW on any 0 sample (counter cleared).
//    S_HIGH -> S_FALL (synced=0) -> S_LOW after DEBOUNCE_CYCLES consecutive 0s; S_FALL -> S_HIGH on any 1.
//    One-cycle registered pulse on the S_RISE->S_HIGH transition only. Pulse asserted exactly
//    DEBOUNCE_CYCLES+2 clocks after btn first sampled high. Held button: one pulse per press.
//  - Glitches shorter than DEBOUNCE_CYCLES: no pulse, no state change beyond S_RISE/S_FALL.
//  - On step pulse: sub=0 -> acc <= acc + sum; sub=1 -> acc <= acc - sum (ACC_W-bit arithmetic).
//    Carry out of bit ACC_W-1 (add) or borrow (sub) sets ovf; ovf is sticky until clr or rst.
//  - On clr pulse: acc <= 0, ovf <= 0. clr and step pulses in the same cycle: clr wins, step dropped.
//  - led updated every clock (1-cycle latency): disp_sel=1 -> led = {zeros, num2, num1};
//    disp_sel=0 -> led = {ovf, acc}. led never reflects an acc value older than one cycle.
//  - Reset mid-debounce returns FSM to S_LOW; a button held through reset yields one pulse
//    DEBOUNCE_CYCLES+2 clocks after rst deasserts.
//  - Reset mid-operation discards any pending pulse; acc/ovf cleared on the same edge.
// CONFIGURATION
//  SW_ACCUM_SAT_EN defined: saturating arithmetic; add clamps acc at 2**ACC_W-1, subtract clamps at 0;
//    ovf sets whenever a clamp occurs.
//  SW_ACCUM_SAT_EN undefined: modulo 2**ACC_W wrap-around; ovf sets on carry/borrow as above.
// STRUCTURE
//  - sw_adder_pkg: debouncer state enum (S_LOW, S_RISE, S_HIGH, S_FALL), clog2-based counter-width
//    constant helper, display-select encoding constants.
//  - Sub-module btn_debounce (param DEBOUNCE_CYCLES; ports clk, rst, btn_raw, pulse), instantiated
//    twice (step, clr). Accumulator, overflow and LED mux live in sw_accum_adder.
// TESTING  (bench uses WIDTH=3, ACC_W=7, DEBOUNCE_CYCLES=4)
//  1 Reset: hold rst 3 cycles with buttons high -> led=0x00; one step pulse exactly 6 clocks after rst low.
//  2 num1=5,num2=6,sub=0, 3 clean step presses -> acc=33, led=0x21, ovf=0; disp_sel=1 -> led=0x35.
//  3 Bounce: btn_step high 3 cycles, low 1, high 3, low -> no pulse, acc unchanged.
//  4 acc=120, add 7+7 -> wrap: led={1,7'd6}=0x86; with SW_ACCUM_SAT_EN -> led=0xFF (acc=127, ovf=1).
//  5 acc=3, sub=1, num1=2,num2=2 -> wrap: led=0xFF (acc=127, ovf=1); SAT_EN build -> led=0x80.
//  6 Step and clr pulses forced same cycle with acc=10 -> acc=0, ovf=0, led=0x00 next cycle.

Source files
------------

// File: rtl/sw_adder_pkg.sv
// Shared types and constants for the switch accumulator and its button debouncers.
`timescale 1ns/1ps

package sw_adder_pkg;

    // Debouncer states: stable low, candidate rise, stable high, candidate fall
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } db_state_e;

    // Values of the display-select switch
    localparam logic DISP_ACC = 1'b0;
    localparam logic DISP_SW  = 1'b1;

    // Width of a counter that must hold values up to cycles-1
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer. Emits a one-cycle pulse once a rising level has
// been stable for DEBOUNCE_CYCLES consecutive synchronised samples.
`timescale 1ns/1ps

module btn_debounce
    import sw_adder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned    CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    // Next-state logic; the sample that leaves a stable state counts as the first stable sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (sync2_q) begin
                    state_d = S_RISE;
                    cnt_d   = CntW'(1);
                end
            end
            S_RISE: begin
                if (!sync2_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_HIGH: begin
                if (!sync2_q) begin
                    state_d = S_FALL;
                    cnt_d   = CntW'(1);
                end
            end
            S_FALL: begin
                if (sync2_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Synchroniser, FSM state, counter and registered pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/sw_accum_adder.sv
// Switch adder with button-stepped accumulator, add/subtract, sticky overflow and LED display.
// Define SW_ACCUM_SAT_EN for saturating arithmetic; otherwise the accumulator wraps.
`timescale 1ns/1ps

module sw_accum_adder
    import sw_adder_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned ACC_W           = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH+1:0] sw,
    input  logic               btn_step,
    input  logic               btn_clr,
    output logic [ACC_W:0]     led
);

    logic [WIDTH-1:0] num1, num2;
    logic             sub, disp_sel;
    logic [WIDTH:0]   sum;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W:0]   add_full, sub_full;
    logic             step_pulse, clr_pulse;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   led_q, led_d;

    assign num1     = sw[WIDTH-1:0];
    assign num2     = sw[2*WIDTH-1:WIDTH];
    assign sub      = sw[2*WIDTH];
    assign disp_sel = sw[2*WIDTH+1];

    assign sum      = {1'b0, num1} + {1'b0, num2};
    assign sum_ext  = ACC_W'(sum);
    // Top bit is carry for add, borrow for subtract
    assign add_full = {1'b0, acc_q} + {1'b0, sum_ext};
    assign sub_full = {1'b0, acc_q} - {1'b0, sum_ext};

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_step),
        .pulse  (step_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_clr),
        .pulse  (clr_pulse)
    );

    // Accumulator update; clear takes priority over a coincident step
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_pulse) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (step_pulse) begin
`ifdef SW_ACCUM_SAT_EN
            if (sub) begin
                if (sub_full[ACC_W]) begin
                    acc_d = '0;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = sub_full[ACC_W-1:0];
                end
            end else begin
                if (add_full[ACC_W]) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = add_full[ACC_W-1:0];
                end
            end
`else
            if (sub) begin
                acc_d = sub_full[ACC_W-1:0];
                ovf_d = ovf_q | sub_full[ACC_W];
            end else begin
                acc_d = add_full[ACC_W-1:0];
                ovf_d = ovf_q | add_full[ACC_W];
            end
`endif
        end
    end

    // Display mux: raw operands or overflow flag plus accumulator
    always_comb begin
        led_d = {ovf_q, acc_q};
        if (disp_sel == DISP_SW) begin
            led_d = (ACC_W+1)'({num2, num1});
        end
    end

    // State and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            led_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule
